// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: edge ticks, half-period measurement, lock/fault FSM.
// Optional MON_SYNC_EN adds a two-flop synchronizer ahead of the sampler (+2 cycles latency).
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 6,
  parameter int TOL      = 0,
  parameter int LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             locked,
  output logic             fault
);

  localparam int GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

  typedef logic [CNT_W:0] ext_t;
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

  localparam ext_t             HI      = ext_t'(EXP_HALF + TOL);
  localparam ext_t             LO      = ext_t'((TOL >= EXP_HALF) ? 0 : (EXP_HALF - TOL));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(EXP_HALF + TOL);
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_N);

  logic             din;
  logic             s_cur;
  logic             s_prev;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic [GW-1:0]    good_inc;
  state_t           state;
  logic             edge_det;
  logic             good;
  logic             timeout;
  ext_t             meas;

`ifdef MON_SYNC_EN
  logic sync_a;
  logic sync_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= clk_div_in;
      sync_b <= sync_a;
    end
  end

  assign din = sync_b;
`else
  assign din = clk_div_in;
`endif

  // meas is one bit wider than cnt so a saturated count still compares correctly
  assign edge_det = s_cur ^ s_prev;
  assign meas     = {1'b0, cnt} + ext_t'(1);
  assign good     = (meas >= LO) && (meas <= HI);
  assign timeout  = !edge_det && (cnt == TO_CNT);
  assign good_inc = good_cnt + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_cur       <= 1'b0;
      s_prev      <= 1'b0;
      cnt         <= '0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      half_period <= '0;
    end else begin
      s_cur     <= din;
      s_prev    <= s_cur;
      rise_tick <= edge_det & s_cur;
      fall_tick <= edge_det & ~s_cur;
      if (edge_det) begin
        cnt <= '0;
        // the first edge after reset has no reference point
        if (state != IDLE)
          half_period <= meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_det) begin
            state    <= ACQ;
            good_cnt <= '0;
          end
        end
        ACQ: begin
          if (edge_det && good) begin
            good_cnt <= good_inc;
            if (good_inc >= LOCK_V) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else if (edge_det || timeout) begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if ((edge_det && !good) || timeout) begin
            state  <= FAULT;
            locked <= 1'b0;
            fault  <= 1'b1;
          end
        end
        FAULT: begin
          if (edge_det && good) begin
            fault    <= 1'b0;
            good_cnt <= GW'(1);
            if (LOCK_N == 1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= ACQ;
            end
          end
        end
        default: begin
          state    <= IDLE;
          good_cnt <= '0;
          locked   <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: event-level reference model plus directed checks.
module tb_clk_div_monitor;

  localparam int EXP    = 6;
  localparam int LOCK_N = 4;
`ifdef MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       rise;
    logic       fall;
    logic [7:0] hp;
    logic       lk;
    logic       ft;
  } res_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       din   = 1'b0;
  logic       din_t = 1'b0;
  logic       rise_tick, fall_tick, locked, fault;
  logic [7:0] half_period;
  logic       rise_t, fall_t, locked_t, fault_t;
  logic [7:0] hp_t;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(8), .EXP_HALF(EXP), .TOL(0), .LOCK_N(LOCK_N)) u_dut (
    .clk(clk), .rst(rst), .clk_div_in(din),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .half_period(half_period),
    .locked(locked), .fault(fault)
  );

  clk_div_monitor #(.CNT_W(8), .EXP_HALF(EXP), .TOL(1), .LOCK_N(LOCK_N)) u_tol (
    .clk(clk), .rst(rst), .clk_div_in(din_t),
    .rise_tick(rise_t), .fall_tick(fall_t), .half_period(hp_t),
    .locked(locked_t), .fault(fault_t)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: works on sampled input levels and run lengths between edges,
  // outputs are delayed by the pipeline latency through a queue.
  res_t pipe[$];
  res_t exp_o = '0;
  int   m_run, m_streak, meas;
  bit   m_prev, m_started, m_locked, m_fault, e, good, to;
  logic [7:0] m_hp;
  res_t r;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_streak = 0; m_prev = 0; m_started = 0;
      m_locked = 0; m_fault = 0; m_hp = '0;
      pipe.delete();
      for (int i = 0; i < LAT; i++) pipe.push_back('0);
      exp_o = '0;
    end else begin
      e    = (din != m_prev);
      good = 0;
      to   = 0;
      r    = '0;
      r.rise = e && din;
      r.fall = e && !din;
      if (e) begin
        meas  = m_run + 1;
        m_run = 0;
        good  = (meas == EXP);
        if (m_started) m_hp = (meas > 255) ? 8'd255 : 8'(meas);
      end else begin
        to = m_started && (m_run == EXP);
        m_run++;
      end
      m_prev = din;
      if (!m_started) begin
        if (e) begin m_started = 1; m_streak = 0; end
      end else if (m_fault) begin
        if (e && good) begin m_fault = 0; m_streak = 1; m_locked = (LOCK_N == 1); end
      end else if (m_locked) begin
        if ((e && !good) || to) begin m_locked = 0; m_fault = 1; end
      end else begin
        if (e && good) begin
          m_streak++;
          if (m_streak >= LOCK_N) m_locked = 1;
        end else if (e || to) begin
          m_streak = 0;
        end
      end
      r.hp = m_hp;
      r.lk = m_locked;
      r.ft = m_fault;
      pipe.push_back(r);
      exp_o = pipe.pop_front();
    end
  end

  always @(negedge clk) begin
    chk("outputs", 32'({rise_tick, fall_tick, half_period, locked, fault}), 32'(exp_o));
  end

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_t(input logic v, input int n);
    din_t = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int m;
    // reset with the input toggling
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      din = ~din;
      chk("rst_outs", 32'({rise_tick, fall_tick, half_period, locked, fault}), 32'd0);
      chk("rst_outs_tol", 32'({rise_t, fall_t, hp_t, locked_t, fault_t}), 32'd0);
    end
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold(0, 4);

    // steady 6-cycle half-periods
    din = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise_tick && n < 20);
    chk("rise_latency", 32'(n), 32'(LAT + 1));
    hold(1, 6 - n);
    hold(0, 6); hold(1, 6); hold(0, 6);
    chk("not_locked_3", 32'(locked), 32'd0);
    hold(1, 6);
    chk("locked_4", 32'(locked), 32'd1);
    chk("hp_6", 32'(half_period), 32'd6);
    hold(0, 6);

    // one long half-period
    hold(1, 8);
    hold(0, 6);
    chk("long_fault", 32'(fault), 32'd1);
    chk("long_unlock", 32'(locked), 32'd0);
    chk("hp_8", 32'(half_period), 32'd8);
    hold(1, 6);
    chk("recover_fault", 32'(fault), 32'd0);
    chk("recover_acq", 32'(locked), 32'd0);
    hold(0, 6); hold(1, 6); hold(0, 6);
    chk("relock", 32'(locked), 32'd1);

    // missing edge: input stuck low
    hold(1, 6);
    din = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!fall_tick && n < 20);
    chk("fall_seen", 32'(fall_tick), 32'd1);
    m = 0;
    do begin @(negedge clk); m++; end while (!fault && m < 40);
    chk("timeout_delay", 32'(m), 32'd7);
    hold(0, 300);
    hold(1, 6);
    chk("hp_saturate", 32'(half_period), 32'd255);
    chk("sat_fault", 32'(fault), 32'd1);
    hold(0, 6);
    chk("sat_recover", 32'(fault), 32'd0);

    // reset mid-operation, input high across release
    din = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_hp", 32'(half_period), 32'd0);
    rst = 1'b0;
    hold(1, 6);
    chk("post_rst_hp", 32'(half_period), 32'd0);
    chk("post_rst_lock", 32'(locked), 32'd0);
    hold(0, 6);
    chk("post_rst_meas", 32'(half_period), 32'd6);

    // tolerance instance: 5,7,6,5 lock, then 8 faults
    hold_t(1, 5); hold_t(0, 7); hold_t(1, 6); hold_t(0, 5);
    chk("tol_not_locked", 32'(locked_t), 32'd0);
    hold_t(1, 5);
    chk("tol_locked", 32'(locked_t), 32'd1);
    chk("tol_hp_5", 32'(hp_t), 32'd5);
    hold_t(1, 3);
    hold_t(0, 6);
    chk("tol_fault", 32'(fault_t), 32'd1);
    chk("tol_hp_8", 32'(hp_t), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
